wb_interconnect_2m1s: RTL and testbench
=======================================

// Module: wb_interconnect_2m1s
// PURPOSE
//  Wishbone B4 arbiter/mux that joins two core masters onto one shared slave (unified memory).
//  m0 is the D$/LSU port. m1 is the I$ fetch port (read-only, burst-capable).
//  It grants one master at a time, routes request signals to the slave and routes responses back.
//  Address translation is outside this block; the block passes addresses through unchanged.
// PARAMETERS
//  DW   32  data width
//  AW   32  address width
//  BLW  10  burst-length field width
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst          in   1     reset, synchronous, active-high
//  m0_wbd_dat_i in   DW    m0 write data
//  m0_wbd_adr_i in   AW    m0 address
//  m0_wbd_sel_i in   DW/8  m0 byte selects
//  m0_wbd_we_i  in   1     m0 write enable
//  m0_wbd_cyc_i in   1     m0 cycle
//  m0_wbd_stb_i in   1     m0 strobe
//  m0_wbd_dat_o out  DW    m0 read data
//  m0_wbd_ack_o out  1     m0 ack
//  m0_wbd_lack_o out 1     m0 last-beat ack
//  m0_wbd_err_o out  1     m0 error
//  m1_wbd_dat_i in   DW    m1 write data
//  m1_wbd_adr_i in   AW    m1 address
//  m1_wbd_sel_i in   DW/8  m1 byte selects
//  m1_wbd_bl_i  in   BLW   m1 burst length
//  m1_wbd_bry_i in   1     m1 burst ready
//  m1_wbd_we_i  in   1     m1 write enable
//  m1_wbd_cyc_i in   1     m1 cycle
//  m1_wbd_stb_i in   1     m1 strobe
//  m1_wbd_dat_o out  DW    m1 read data
//  m1_wbd_ack_o out  1     m1 ack
//  m1_wbd_lack_o out 1     m1 last-beat ack
//  m1_wbd_err_o out  1     m1 error
//  s_wbd_dat_i  in   DW    slave read data
//  s_wbd_ack_i  in   1     slave ack
//  s_wbd_lack_i in   1     slave last-beat ack
//  s_wbd_dat_o  out  DW    slave write data
//  s_wbd_adr_o  out  AW    slave address
//  s_wbd_sel_o  out  DW/8  slave byte selects
//  s_wbd_bl_o   out  BLW   slave burst length
//  s_wbd_bry_o  out  1     slave burst ready
//  s_wbd_we_o   out  1     slave write enable
//  s_wbd_cyc_o  out  1     slave cycle
//  s_wbd_stb_o  out  1     slave strobe
// BEHAVIOUR
//  State:
//   - owner_vld (1b), owner (1b: 0=m0, 1=m1), last (1b: last granted master).
//   - Reset values: owner_vld=0, owner=0, last=1.
//  Arbitration when owner_vld=0:
//   - Round-robin between the masters asserting cyc.
//   - Both requesting -> grant the master that is not `last`; one requesting -> grant it.
//   - The grant is combinational in the same cycle, so a request is forwarded to the slave
//     in the cycle its cyc rises (zero added latency).
//   - On that edge: owner_vld<=1, owner<=winner, last<=winner.
//  Lock:
//   - While owner_vld=1, ownership is held until the owner deasserts cyc.
//   - On the edge where the owner's cyc is 0: owner_vld<=0. The next grant may occur in that
//     same cycle if the other master requests.
//   - A non-owner request waits with ack=0 and has no effect on the slave.
//  Forwarding:
//   - Slave outputs = granted master's signals (dat, adr, sel, we, cyc, stb).
//   - s_wbd_bl_o: m1 -> m1_wbd_bl_i; m0 -> 1. s_wbd_bry_o: m1 -> m1_wbd_bry_i; m0 -> 1.
//   - No grant: every slave output is 0 (cyc=stb=we=0).
//  Responses:
//   - Granted master's ack_o/lack_o = s_wbd_ack_i/s_wbd_lack_i, combinational.
//   - Non-granted master: ack_o=0, lack_o=0.
//   - dat_o = s_wbd_dat_i for the granted master, 0 otherwise.
//   - err_o is constant 0 for both masters (single slave, no decode error).
//  Reset:
//   - Reset mid-transaction drops the grant in the next cycle.
//   - While rst=1, all slave outputs and master acks are 0.
//  Slave timing:
//   - Acks may arrive any number of cycles after stb, or be held continuously while cyc is high.
//   - The interconnect adds no cycles.
// TESTING
//  1. m0 write only: cyc/stb/we=1, adr=0x1000, dat=1, sel=0xF
//     -> same cycle s_adr=0x1000, s_dat=1, s_we=1; s_ack=1 -> m0_ack=1, m1_ack=0.
//  2. m1 read only: adr=0x0, s_dat_i=0x00000513, s_ack=1 -> m1_dat_o=0x00000513, m1_ack=1, m0_dat_o=0.
//  3. Both cyc rise the same cycle after reset (last=1) -> m0 granted.
//     m0 drops cyc -> m1 granted in that cycle.
//     Both request again -> m0 granted (round-robin).
//  4. m0 owns with 3 held acks; m1 raises cyc mid-transfer
//     -> s_adr stays m0's; m1_ack=0 until m0 cyc=0.
//  5. m1 burst with bl=8, bry=1 -> s_bl_o=8, s_bry_o=1; s_lack on 8th beat -> m1_lack=1 only.
//  6. Assert rst during an m1 transfer -> next cycle s_cyc=0, all acks 0;
//     after release, the first requester is granted.

Source files
------------

// File: rtl/wb_interconnect_2m1s_if.sv
// Bus bundle for the two-master / one-slave Wishbone interconnect.
// The "slave" modport is the interconnect's view. The "master" modport is the
// environment's view: the two core masters and the shared memory.
interface wb_interconnect_2m1s_if #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BLW = 10
);
    // m0: D$/LSU port
    logic [DW-1:0]   m0_wbd_dat_i;
    logic [AW-1:0]   m0_wbd_adr_i;
    logic [DW/8-1:0] m0_wbd_sel_i;
    logic            m0_wbd_we_i;
    logic            m0_wbd_cyc_i;
    logic            m0_wbd_stb_i;
    logic [DW-1:0]   m0_wbd_dat_o;
    logic            m0_wbd_ack_o;
    logic            m0_wbd_lack_o;
    logic            m0_wbd_err_o;
    // m1: I$ fetch port, burst-capable
    logic [DW-1:0]   m1_wbd_dat_i;
    logic [AW-1:0]   m1_wbd_adr_i;
    logic [DW/8-1:0] m1_wbd_sel_i;
    logic [BLW-1:0]  m1_wbd_bl_i;
    logic            m1_wbd_bry_i;
    logic            m1_wbd_we_i;
    logic            m1_wbd_cyc_i;
    logic            m1_wbd_stb_i;
    logic [DW-1:0]   m1_wbd_dat_o;
    logic            m1_wbd_ack_o;
    logic            m1_wbd_lack_o;
    logic            m1_wbd_err_o;
    // shared slave
    logic [DW-1:0]   s_wbd_dat_i;
    logic            s_wbd_ack_i;
    logic            s_wbd_lack_i;
    logic [DW-1:0]   s_wbd_dat_o;
    logic [AW-1:0]   s_wbd_adr_o;
    logic [DW/8-1:0] s_wbd_sel_o;
    logic [BLW-1:0]  s_wbd_bl_o;
    logic            s_wbd_bry_o;
    logic            s_wbd_we_o;
    logic            s_wbd_cyc_o;
    logic            s_wbd_stb_o;

    modport slave (
        input  m0_wbd_dat_i, m0_wbd_adr_i, m0_wbd_sel_i, m0_wbd_we_i,
               m0_wbd_cyc_i, m0_wbd_stb_i,
        output m0_wbd_dat_o, m0_wbd_ack_o, m0_wbd_lack_o, m0_wbd_err_o,
        input  m1_wbd_dat_i, m1_wbd_adr_i, m1_wbd_sel_i, m1_wbd_bl_i,
               m1_wbd_bry_i, m1_wbd_we_i, m1_wbd_cyc_i, m1_wbd_stb_i,
        output m1_wbd_dat_o, m1_wbd_ack_o, m1_wbd_lack_o, m1_wbd_err_o,
        input  s_wbd_dat_i, s_wbd_ack_i, s_wbd_lack_i,
        output s_wbd_dat_o, s_wbd_adr_o, s_wbd_sel_o, s_wbd_bl_o,
               s_wbd_bry_o, s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o
    );

    modport master (
        output m0_wbd_dat_i, m0_wbd_adr_i, m0_wbd_sel_i, m0_wbd_we_i,
               m0_wbd_cyc_i, m0_wbd_stb_i,
        input  m0_wbd_dat_o, m0_wbd_ack_o, m0_wbd_lack_o, m0_wbd_err_o,
        output m1_wbd_dat_i, m1_wbd_adr_i, m1_wbd_sel_i, m1_wbd_bl_i,
               m1_wbd_bry_i, m1_wbd_we_i, m1_wbd_cyc_i, m1_wbd_stb_i,
        input  m1_wbd_dat_o, m1_wbd_ack_o, m1_wbd_lack_o, m1_wbd_err_o,
        output s_wbd_dat_i, s_wbd_ack_i, s_wbd_lack_i,
        input  s_wbd_dat_o, s_wbd_adr_o, s_wbd_sel_o, s_wbd_bl_o,
               s_wbd_bry_o, s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o
    );
endinterface

// File: rtl/wb_interconnect_2m1s.sv
// Two-master Wishbone arbiter/mux onto one shared slave.
// Round-robin grant, locked to the owner until its cyc drops. The grant is
// combinational, so a request reaches the slave in the cycle its cyc rises.
module wb_interconnect_2m1s #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BLW = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_interconnect_2m1s_if.slave   bus
);
    logic r_owner_vld;
    logic r_owner;     // 0 = m0, 1 = m1
    logic r_last;      // last granted master, resets to m1 so m0 wins the first tie

    logic w_hold;
    logic w_gnt_vld;
    logic w_gnt;
    logic w_sel_m0;
    logic w_sel_m1;

    logic [DW-1:0]   w_dat;
    logic [AW-1:0]   w_adr;
    logic [DW/8-1:0] w_sel;
    logic [BLW-1:0]  w_bl;

    // Grant: keep the owner while its cyc is high, otherwise arbitrate round-robin.
    // Reset forces no grant so nothing reaches the slave while rst is high.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_owner;
        w_hold    = r_owner_vld && (r_owner ? bus.m1_wbd_cyc_i : bus.m0_wbd_cyc_i);
        if (rst) begin
            w_gnt_vld = 1'b0;
        end else if (w_hold) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_owner;
        end else if (bus.m0_wbd_cyc_i && bus.m1_wbd_cyc_i) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ~r_last;
        end else if (bus.m0_wbd_cyc_i) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b0;
        end else if (bus.m1_wbd_cyc_i) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
        end
    end

    // Ownership register: follows the grant; released on the edge the owner drops cyc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_vld <= 1'b0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_owner_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_owner <= w_gnt;
                r_last  <= w_gnt;
            end
        end
    end

    assign w_sel_m0 = w_gnt_vld & ~w_gnt;
    assign w_sel_m1 = w_gnt_vld &  w_gnt;

    // Request mux: granted master's signals, all zero when nobody is granted.
    // m0 has no burst interface, so it is presented as single-beat, always ready.
    always_comb begin
        w_dat = '0;
        w_adr = '0;
        w_sel = '0;
        w_bl  = '0;
        if (w_sel_m1) begin
            w_dat = bus.m1_wbd_dat_i;
            w_adr = bus.m1_wbd_adr_i;
            w_sel = bus.m1_wbd_sel_i;
            w_bl  = bus.m1_wbd_bl_i;
        end else if (w_sel_m0) begin
            w_dat = bus.m0_wbd_dat_i;
            w_adr = bus.m0_wbd_adr_i;
            w_sel = bus.m0_wbd_sel_i;
            w_bl  = BLW'(1);
        end
    end

    assign bus.s_wbd_dat_o = w_dat;
    assign bus.s_wbd_adr_o = w_adr;
    assign bus.s_wbd_sel_o = w_sel;
    assign bus.s_wbd_bl_o  = w_bl;
    assign bus.s_wbd_bry_o = w_sel_m1 ? bus.m1_wbd_bry_i : w_sel_m0;
    assign bus.s_wbd_we_o  = (w_sel_m1 & bus.m1_wbd_we_i)  | (w_sel_m0 & bus.m0_wbd_we_i);
    assign bus.s_wbd_cyc_o = (w_sel_m1 & bus.m1_wbd_cyc_i) | (w_sel_m0 & bus.m0_wbd_cyc_i);
    assign bus.s_wbd_stb_o = (w_sel_m1 & bus.m1_wbd_stb_i) | (w_sel_m0 & bus.m0_wbd_stb_i);

    // Responses go only to the granted master; single slave, so never an error.
    assign bus.m0_wbd_dat_o  = w_sel_m0 ? bus.s_wbd_dat_i : '0;
    assign bus.m0_wbd_ack_o  = w_sel_m0 & bus.s_wbd_ack_i;
    assign bus.m0_wbd_lack_o = w_sel_m0 & bus.s_wbd_lack_i;
    assign bus.m0_wbd_err_o  = 1'b0;
    assign bus.m1_wbd_dat_o  = w_sel_m1 ? bus.s_wbd_dat_i : '0;
    assign bus.m1_wbd_ack_o  = w_sel_m1 & bus.s_wbd_ack_i;
    assign bus.m1_wbd_lack_o = w_sel_m1 & bus.s_wbd_lack_i;
    assign bus.m1_wbd_err_o  = 1'b0;
endmodule

// File: tb/tb_wb_interconnect_2m1s.sv
// Directed bench for wb_interconnect_2m1s. Each step drives the inputs, pushes
// the expected outputs (routing of the master the bench says should own the
// bus) to a queue, and pops/compares them once the outputs have settled.
module tb_wb_interconnect_2m1s;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BLW = 10;

    typedef struct packed {
        logic [DW-1:0]   s_dat;
        logic [AW-1:0]   s_adr;
        logic [DW/8-1:0] s_sel;
        logic [BLW-1:0]  s_bl;
        logic            s_bry;
        logic            s_we;
        logic            s_cyc;
        logic            s_stb;
        logic [DW-1:0]   m0_dat;
        logic            m0_ack;
        logic            m0_lack;
        logic            m0_err;
        logic [DW-1:0]   m1_dat;
        logic            m1_ack;
        logic            m1_lack;
        logic            m1_err;
    } obs_t;

    logic clk;
    logic rst;
    int   tests;
    int   failures;
    obs_t exp_q[$];
    string tag_q[$];

    wb_interconnect_2m1s_if #(.DW(DW), .AW(AW), .BLW(BLW)) bus ();

    wb_interconnect_2m1s #(.DW(DW), .AW(AW), .BLW(BLW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.s_dat   = bus.s_wbd_dat_o;
        o.s_adr   = bus.s_wbd_adr_o;
        o.s_sel   = bus.s_wbd_sel_o;
        o.s_bl    = bus.s_wbd_bl_o;
        o.s_bry   = bus.s_wbd_bry_o;
        o.s_we    = bus.s_wbd_we_o;
        o.s_cyc   = bus.s_wbd_cyc_o;
        o.s_stb   = bus.s_wbd_stb_o;
        o.m0_dat  = bus.m0_wbd_dat_o;
        o.m0_ack  = bus.m0_wbd_ack_o;
        o.m0_lack = bus.m0_wbd_lack_o;
        o.m0_err  = bus.m0_wbd_err_o;
        o.m1_dat  = bus.m1_wbd_dat_o;
        o.m1_ack  = bus.m1_wbd_ack_o;
        o.m1_lack = bus.m1_wbd_lack_o;
        o.m1_err  = bus.m1_wbd_err_o;
        return o;
    endfunction

    // Reference routing: g = 0 none, 1 m0 owns, 2 m1 owns.
    function automatic obs_t expect_for(int g);
        obs_t e;
        e = '0;
        if (g == 1) begin
            e.s_dat  = bus.m0_wbd_dat_i;
            e.s_adr  = bus.m0_wbd_adr_i;
            e.s_sel  = bus.m0_wbd_sel_i;
            e.s_bl   = 10'd1;
            e.s_bry  = 1'b1;
            e.s_we   = bus.m0_wbd_we_i;
            e.s_cyc  = bus.m0_wbd_cyc_i;
            e.s_stb  = bus.m0_wbd_stb_i;
            e.m0_dat = bus.s_wbd_dat_i;
            e.m0_ack = bus.s_wbd_ack_i;
            e.m0_lack = bus.s_wbd_lack_i;
        end else if (g == 2) begin
            e.s_dat  = bus.m1_wbd_dat_i;
            e.s_adr  = bus.m1_wbd_adr_i;
            e.s_sel  = bus.m1_wbd_sel_i;
            e.s_bl   = bus.m1_wbd_bl_i;
            e.s_bry  = bus.m1_wbd_bry_i;
            e.s_we   = bus.m1_wbd_we_i;
            e.s_cyc  = bus.m1_wbd_cyc_i;
            e.s_stb  = bus.m1_wbd_stb_i;
            e.m1_dat = bus.s_wbd_dat_i;
            e.m1_ack = bus.s_wbd_ack_i;
            e.m1_lack = bus.s_wbd_lack_i;
        end
        return e;
    endfunction

    // Inputs are already driven for this cycle; check at the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input int g, input string tag);
        obs_t  e;
        obs_t  o;
        string t;
        exp_q.push_back(expect_for(g));
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observe();
        tests++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic m0_req(input logic cyc, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat);
        bus.m0_wbd_cyc_i = cyc;
        bus.m0_wbd_stb_i = cyc;
        bus.m0_wbd_we_i  = we;
        bus.m0_wbd_adr_i = adr;
        bus.m0_wbd_dat_i = dat;
        bus.m0_wbd_sel_i = 4'hF;
    endtask

    task automatic m1_req(input logic cyc, input logic [AW-1:0] adr,
                          input logic [BLW-1:0] bl, input logic bry);
        bus.m1_wbd_cyc_i = cyc;
        bus.m1_wbd_stb_i = cyc;
        bus.m1_wbd_we_i  = 1'b0;
        bus.m1_wbd_adr_i = adr;
        bus.m1_wbd_dat_i = 32'hDEAD_0001;
        bus.m1_wbd_sel_i = 4'hF;
        bus.m1_wbd_bl_i  = bl;
        bus.m1_wbd_bry_i = bry;
    endtask

    task automatic slv(input logic ack, input logic lack, input logic [DW-1:0] dat);
        bus.s_wbd_ack_i  = ack;
        bus.s_wbd_lack_i = lack;
        bus.s_wbd_dat_i  = dat;
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        m0_req(1'b0, 1'b0, '0, '0);
        m1_req(1'b0, '0, '0, 1'b0);
        slv(1'b0, 1'b0, '0);
        @(posedge clk); #1;
        m0_req(1'b1, 1'b1, 32'h0000_0040, 32'h5);
        slv(1'b1, 1'b1, 32'h1234);
        step(0, "rst_blocks_req");
        step(0, "rst_blocks_req2");
        rst = 1'b0;
        m0_req(1'b0, 1'b0, '0, '0);
        slv(1'b0, 1'b0, '0);
        step(0, "idle_after_rst");

        // 1: m0 single write, acked in the same cycle
        m0_req(1'b1, 1'b1, 32'h0000_1000, 32'h1);
        slv(1'b1, 1'b0, 32'h0);
        step(1, "t1_m0_write");
        m0_req(1'b0, 1'b0, '0, '0);
        slv(1'b0, 1'b0, '0);
        step(0, "t1_release");

        // 2: m1 read, response data only to m1
        m1_req(1'b1, 32'h0, 10'd1, 1'b1);
        slv(1'b1, 1'b1, 32'h0000_0513);
        step(2, "t2_m1_read");
        m1_req(1'b0, '0, '0, 1'b0);
        slv(1'b0, 1'b0, '0);
        step(0, "t2_release");

        // 3: tie with last=m1 -> m0; m0 drops -> m1 same cycle; tie again -> m0
        m0_req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        m1_req(1'b1, 32'h0000_0200, 10'd1, 1'b1);
        slv(1'b1, 1'b0, 32'hAAAA_0001);
        step(1, "t3_tie_m0");
        step(1, "t3_m0_holds");
        m0_req(1'b0, 1'b0, '0, '0);
        step(2, "t3_handover_m1");
        step(2, "t3_m1_holds");
        m1_req(1'b0, '0, '0, 1'b0);
        step(0, "t3_gap");
        m0_req(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        m1_req(1'b1, 32'h0000_0204, 10'd1, 1'b1);
        step(1, "t3_tie_rr_m0");
        m0_req(1'b0, 1'b0, '0, '0);
        m1_req(1'b0, '0, '0, 1'b0);
        step(0, "t3_release");

        // 4: m0 owns across 3 held acks, m1 request waits
        m0_req(1'b1, 1'b1, 32'h0000_2000, 32'h0000_0077);
        slv(1'b1, 1'b0, 32'h0);
        step(1, "t4_beat1");
        m1_req(1'b1, 32'h0000_3000, 10'd1, 1'b1);
        step(1, "t4_beat2_m1_waits");
        step(1, "t4_beat3_m1_waits");
        m0_req(1'b0, 1'b0, '0, '0);
        step(2, "t4_m1_takes_over");
        m1_req(1'b0, '0, '0, 1'b0);
        slv(1'b0, 1'b0, '0);
        step(0, "t4_release");

        // 5: m1 burst of 8 after one wait state, lack on the last beat
        m1_req(1'b1, 32'h0000_4000, 10'd8, 1'b1);
        slv(1'b0, 1'b0, '0);
        step(2, "t5_wait_state");
        for (int b = 0; b < 8; b++) begin
            bus.m1_wbd_adr_i = 32'h0000_4000 + 32'(b * 4);
            slv(1'b1, (b == 7), 32'hC0DE_0000 + 32'(b));
            step(2, $sformatf("t5_beat%0d", b));
        end
        m1_req(1'b0, '0, '0, 1'b0);
        slv(1'b0, 1'b0, '0);
        step(0, "t5_release");

        // 6: reset in the middle of an m1 transfer
        m1_req(1'b1, 32'h0000_5000, 10'd4, 1'b1);
        slv(1'b1, 1'b0, 32'h0000_0099);
        step(2, "t6_m1_active");
        rst = 1'b1;
        step(0, "t6_in_rst");
        step(0, "t6_in_rst2");
        rst = 1'b0;
        step(2, "t6_m1_regrant");
        m1_req(1'b0, '0, '0, 1'b0);
        slv(1'b0, 1'b0, '0);
        step(0, "t6_release");
        // reset restores last=m1, so a tie right after reset goes to m0
        rst = 1'b1;
        step(0, "t6_rst_pulse");
        rst = 1'b0;
        m0_req(1'b1, 1'b0, 32'h0000_6000, 32'h0);
        m1_req(1'b1, 32'h0000_7000, 10'd1, 1'b1);
        slv(1'b1, 1'b0, 32'h0000_0042);
        step(1, "t6_tie_after_rst_m0");
        m0_req(1'b0, 1'b0, '0, '0);
        step(2, "t6_then_m1");
        m1_req(1'b0, '0, '0, 1'b0);
        slv(1'b0, 1'b0, '0);
        step(0, "t6_idle");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
